// File: rtl/ysyx_lsu_resp_if.sv
// Bundle between the execute stage, the LSU responder and the AXI4-Lite style data bus.
// The slave modport is the responder's view; master is the requester plus memory side.
interface ysyx_lsu_resp_if #(
    parameter int BIT_W = 32
);
    // Request side: avalid is held until the one-cycle rvalid/wready completion pulse.
    // Bus side: a channel transfers on a clock edge where its valid and ready are both 1;
    // a raised valid and its payload stay stable until that edge.
    logic             lsu_avalid;
    logic [BIT_W-1:0] lsu_addr;
    logic             lsu_ren;
    logic             lsu_wen;
    logic [2:0]       lsu_func3;
    logic [BIT_W-1:0] lsu_wdata;
    logic [BIT_W-1:0] lsu_rdata_o;
    logic             lsu_rvalid_o;
    logic             lsu_wready_o;
    logic             lsu_err_o;

    logic [BIT_W-1:0] araddr_o;
    logic             arvalid_o;
    logic             arready;
    logic [BIT_W-1:0] rdata;
    logic [1:0]       rresp;
    logic             rvalid;
    logic             rready_o;
    logic [BIT_W-1:0] awaddr_o;
    logic             awvalid_o;
    logic             awready;
    logic [BIT_W-1:0] wdata_o;
    logic [3:0]       wstrb_o;
    logic             wvalid_o;
    logic             wready;
    logic [1:0]       bresp;
    logic             bvalid;
    logic             bready_o;

    modport slave (
        input  lsu_avalid, lsu_addr, lsu_ren, lsu_wen, lsu_func3, lsu_wdata,
        output lsu_rdata_o, lsu_rvalid_o, lsu_wready_o, lsu_err_o,
        output araddr_o, arvalid_o, input arready,
        input  rdata, rresp, rvalid, output rready_o,
        output awaddr_o, awvalid_o, input awready,
        output wdata_o, wstrb_o, wvalid_o, input wready,
        input  bresp, bvalid, output bready_o
    );

    modport master (
        output lsu_avalid, lsu_addr, lsu_ren, lsu_wen, lsu_func3, lsu_wdata,
        input  lsu_rdata_o, lsu_rvalid_o, lsu_wready_o, lsu_err_o,
        input  araddr_o, arvalid_o, output arready,
        output rdata, rresp, rvalid, input rready_o,
        input  awaddr_o, awvalid_o, output awready,
        input  wdata_o, wstrb_o, wvalid_o, output wready,
        output bresp, bvalid, input bready_o
    );
endinterface

// File: rtl/ysyx_lsu_resp.sv
// LSU responder: turns one execute-stage memory request into one AR/R or AW+W/B bus
// transaction, with lane placement, strobes, load extension and misalignment detection.
module ysyx_lsu_resp #(
    parameter int BIT_W = 32
) (
    input  logic               clk,
    input  logic               rst,
    ysyx_lsu_resp_if.slave     io,
    output logic               busy_o,
    output logic [2:0]         state_o
);

    typedef enum logic [2:0] {
        S_IDLE  = 3'd0,
        S_RADDR = 3'd1,
        S_RDATA = 3'd2,
        S_WREQ  = 3'd3,
        S_WRESP = 3'd4,
        S_DONE  = 3'd5
    } state_e;

    state_e           state_q;
    logic [1:0]       off_q;
    logic [2:0]       func3_q;
    logic             aw_done_q, w_done_q;
    logic             arvalid_q, rready_q, awvalid_q, wvalid_q, bready_q;
    logic             rvalid_q, wready_q, err_q;
    logic [BIT_W-1:0] araddr_q, awaddr_q, wdata_q, rdata_q;
    logic [3:0]       wstrb_q;

    logic             req_d, misaligned_d, aw_done_d, w_done_d;
    logic [BIT_W-1:0] wdata_d, rshift_d, rext_d;
    logic [3:0]       wstrb_d;

    always_comb begin
        req_d        = io.lsu_avalid & (io.lsu_ren | io.lsu_wen);
        misaligned_d = ((io.lsu_func3[1:0] == 2'd1) & io.lsu_addr[0]) |
                       ((io.lsu_func3[1:0] == 2'd2) & (io.lsu_addr[1:0] != 2'd0));
        wdata_d      = io.lsu_wdata << {io.lsu_addr[1:0], 3'b000};
        case (io.lsu_func3[1:0])
            2'd0:    wstrb_d = 4'b0001 << io.lsu_addr[1:0];
            2'd1:    wstrb_d = 4'b0011 << io.lsu_addr[1:0];
            default: wstrb_d = 4'b1111;
        endcase
        // Loads use the full bus word shifted down to the addressed byte lane.
        rshift_d = io.rdata >> {off_q, 3'b000};
        case (func3_q)
            3'd0:    rext_d = {{(BIT_W-8){rshift_d[7]}}, rshift_d[7:0]};
            3'd1:    rext_d = {{(BIT_W-16){rshift_d[15]}}, rshift_d[15:0]};
            3'd4:    rext_d = {{(BIT_W-8){1'b0}}, rshift_d[7:0]};
            3'd5:    rext_d = {{(BIT_W-16){1'b0}}, rshift_d[15:0]};
            default: rext_d = io.rdata;
        endcase
        aw_done_d = aw_done_q | (awvalid_q & io.awready);
        w_done_d  = w_done_q | (wvalid_q & io.wready);
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q   <= S_IDLE;
            off_q     <= 2'd0;
            func3_q   <= 3'd0;
            aw_done_q <= 1'b0;
            w_done_q  <= 1'b0;
            arvalid_q <= 1'b0;
            rready_q  <= 1'b0;
            awvalid_q <= 1'b0;
            wvalid_q  <= 1'b0;
            bready_q  <= 1'b0;
            rvalid_q  <= 1'b0;
            wready_q  <= 1'b0;
            err_q     <= 1'b0;
            araddr_q  <= '0;
            awaddr_q  <= '0;
            wdata_q   <= '0;
            rdata_q   <= '0;
            wstrb_q   <= 4'd0;
        end else begin
            // Completion outputs are single-cycle; they are raised only on entry to DONE.
            rvalid_q <= 1'b0;
            wready_q <= 1'b0;
            err_q    <= 1'b0;
            case (state_q)
                S_IDLE: begin
                    if (req_d) begin
                        off_q   <= io.lsu_addr[1:0];
                        func3_q <= io.lsu_func3;
                        if (misaligned_d) begin
                            state_q  <= S_DONE;
                            rvalid_q <= io.lsu_ren;
                            wready_q <= ~io.lsu_ren;
                            err_q    <= 1'b1;
                            if (io.lsu_ren) rdata_q <= '0;
                        end else if (io.lsu_ren) begin
                            state_q   <= S_RADDR;
                            arvalid_q <= 1'b1;
                            araddr_q  <= io.lsu_addr;
                        end else begin
                            state_q   <= S_WREQ;
                            awvalid_q <= 1'b1;
                            wvalid_q  <= 1'b1;
                            awaddr_q  <= io.lsu_addr;
                            wdata_q   <= wdata_d;
                            wstrb_q   <= wstrb_d;
                            aw_done_q <= 1'b0;
                            w_done_q  <= 1'b0;
                        end
                    end
                end
                S_RADDR: begin
                    if (io.arready) begin
                        arvalid_q <= 1'b0;
                        rready_q  <= 1'b1;
                        state_q   <= S_RDATA;
                    end
                end
                S_RDATA: begin
                    if (io.rvalid) begin
                        rready_q <= 1'b0;
                        rdata_q  <= rext_d;
                        rvalid_q <= 1'b1;
                        err_q    <= (io.rresp != 2'd0);
                        state_q  <= S_DONE;
                    end
                end
                S_WREQ: begin
                    if (io.awready) awvalid_q <= 1'b0;
                    if (io.wready)  wvalid_q  <= 1'b0;
                    aw_done_q <= aw_done_d;
                    w_done_q  <= w_done_d;
                    if (aw_done_d && w_done_d) begin
                        bready_q <= 1'b1;
                        state_q  <= S_WRESP;
                    end
                end
                S_WRESP: begin
                    if (io.bvalid) begin
                        bready_q <= 1'b0;
                        wready_q <= 1'b1;
                        err_q    <= (io.bresp != 2'd0);
                        state_q  <= S_DONE;
                    end
                end
                S_DONE:  state_q <= S_IDLE;
                default: state_q <= S_IDLE;
            endcase
        end
    end

    assign io.lsu_rdata_o  = rdata_q;
    assign io.lsu_rvalid_o = rvalid_q;
    assign io.lsu_wready_o = wready_q;
    assign io.lsu_err_o    = err_q;
    assign io.araddr_o     = araddr_q;
    assign io.arvalid_o    = arvalid_q;
    assign io.rready_o     = rready_q;
    assign io.awaddr_o     = awaddr_q;
    assign io.awvalid_o    = awvalid_q;
    assign io.wdata_o      = wdata_q;
    assign io.wstrb_o      = wstrb_q;
    assign io.wvalid_o     = wvalid_q;
    assign io.bready_o     = bready_q;
    assign busy_o          = (state_q != S_IDLE);
    assign state_o         = state_q;

endmodule

// File: doc/ysyx_lsu_resp.md
Name: ysyx_lsu_resp

Overview:
- Load/store responder for the execute stage's memory request port; it is the far end of the execute stage's lsu_avalid / rwaddr / ren / wen / wdata request and its rvalid / wready / rdata reply.
- Converts each accepted request into one AXI4-Lite style transaction on the data bus (AR/R or AW+W/B).
- Handles byte-lane placement, write strobes, load sign/zero extension and misalignment.
- Returns exactly one completion pulse per request.

Parameters:
- BIT_W, 32, data and address width; only 32 is supported.

Ports:
- clk  in  1  clock.
- rst  in  1  reset. Asynchronous, active-low: asserted when 0.
- lsu_avalid  in  1  request valid. Held high by the requester until completion.
- lsu_addr  in  BIT_W  byte address. Sampled at accept.
- lsu_ren  in  1  load request. Sampled at accept.
- lsu_wen  in  1  store request. Sampled at accept. ren and wen are never both 1.
- lsu_func3  in  3  access size/sign: 0 LB, 1 LH, 2 LW, 4 LBU, 5 LHU. For stores, only bits [1:0] are used (0 SB, 1 SH, 2 SW).
- lsu_wdata  in  BIT_W  store data, right-aligned. Sampled at accept.
- lsu_rdata_o  out  BIT_W  load result, extended. Valid while lsu_rvalid_o is 1, then held.
- lsu_rvalid_o  out  1  one-cycle load completion pulse.
- lsu_wready_o  out  1  one-cycle store completion pulse.
- lsu_err_o  out  1  high together with a completion pulse when the response was a bus error or a misaligned access.
- busy_o  out  1  high whenever the state is not IDLE.
- araddr_o  out  BIT_W, arvalid_o out 1, arready  in 1.
- rdata  in  BIT_W, rresp in 2, rvalid in 1, rready_o out 1.
- awaddr_o  out  BIT_W, awvalid_o out 1, awready  in 1.
- wdata_o  out  BIT_W, wstrb_o out 4, wvalid_o out 1, wready in 1.
- bresp  in  2, bvalid in 1, bready_o out 1.

Behaviour:
- States: IDLE, RADDR, RDATA, WREQ, WRESP, DONE.
- IDLE: if lsu_avalid & (ren|wen), capture addr, func3, wdata and the ren/wen kind.
  - Misaligned access (func3[1:0]==1 with addr[0]==1, or func3[1:0]==2 with addr[1:0]!=0) issues no bus transaction: go to DONE with err=1 and rdata=0.
  - Otherwise ren goes to RADDR and wen goes to WREQ.
  - avalid with neither ren nor wen is ignored.
- RADDR:
  - arvalid_o=1, araddr_o = captured address (not lane-aligned).
  - Go to RDATA on arready.
  - arvalid_o and araddr_o stay stable until accepted.
- RDATA: rready_o=1. On rvalid, latch the result and err=(rresp!=0), then go to DONE.
  - Result: shift rdata right by 8*addr[1:0].
  - LB/LH sign-extend from bit 7/15. LBU/LHU zero-extend. LW is taken unmodified.
- WREQ:
  - awvalid_o and wvalid_o are both asserted on entry.
  - Each channel drops independently once its ready is seen. A per-channel done flag covers AW and W completing in different cycles.
  - Go to WRESP when both are done; this includes both completing in the same cycle.
  - wdata_o = wdata << 8*addr[1:0].
  - wstrb_o = (SB 4'b0001, SH 4'b0011, SW 4'b1111) << addr[1:0].
- WRESP: bready_o=1. On bvalid, set err=(bresp!=0) and go to DONE.
- DONE:
  - Exactly one cycle: lsu_rvalid_o (load) or lsu_wready_o (store) =1, and lsu_err_o = err.
  - Then go to IDLE.
  - The requester deasserts lsu_avalid on the clock edge ending DONE. IDLE therefore cannot re-accept the same request.
- Latency with zero-wait bus, measured from the accept edge to the completion pulse cycle:
  - load: RADDR, RDATA, DONE, so the pulse is in the 3rd cycle after accept.
  - store: the same, via WREQ, WRESP, DONE.
  - misaligned: the pulse is in the 1st cycle after accept.
- Bus wait states stretch RADDR, RDATA, WREQ or WRESP indefinitely. There is no timeout.
- lsu_rdata_o holds the last load result until the next load completes. A store does not change it.
- A bus error on a load still returns the extended rdata, with lsu_err_o=1.
- Reset (rst=0, async, also mid-transaction):
  - state=IDLE.
  - All valid/ready/pulse outputs, busy_o and lsu_err_o go to 0 immediately.
  - lsu_rdata_o=0, address/data outputs=0, wstrb_o=0.
  - Any outstanding bus transaction is abandoned.

Test Plan:
- LB at 0x8000_0003, bus returns rdata=0x80FF_1234 with zero wait → lsu_rvalid_o pulses 3 cycles after accept, lsu_rdata_o=0xFFFF_FF80, lsu_err_o=0; arvalid_o high for exactly 1 cycle.
- LHU at 0x8000_0002, rdata=0xBEEF_0000 → lsu_rdata_o=0x0000_BEEF. The same access as LH → 0xFFFF_BEEF.
- SB at 0x8000_0001, wdata=0x1234_56AB → wdata_o=0x3456_AB00, wstrb_o=0010. awready arrives 2 cycles before wready: AW drops after its handshake, W is held; lsu_wready_o pulses once, after bvalid.
- SW at 0x8000_0002 → no awvalid_o/wvalid_o at all; lsu_wready_o and lsu_err_o both pulse 1 cycle after accept. LH at 0x…1 → the same, on the read side, with rdata=0.
- LW with arready delayed 4 cycles and rresp=2'b10 → araddr_o stable throughout; completion pulse with lsu_err_o=1.
- rst=0 while in RDATA → rready_o, busy_o and lsu_rdata_o are 0 asynchronously. After release, a fresh LW completes normally with no stale pulse.
